// File: rtl/regfile_write_buffer_pkg.sv
// Shared definitions for the register-file write buffer and the execute/writeback stage.
package regfile_write_buffer_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_buffer_if.sv
// Writeback request, register-file write port and forwarding signals of the write buffer.
interface regfile_write_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              drain_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic              fwd_hit1;
  logic [DATA_W-1:0] fwd_data1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data2;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  modport master (
    output in_valid, in_addr, in_data, drain_en, rd_addr1, rd_addr2,
    input  in_ready, wr_en, wr_addr, wr_data, fwd_hit1, fwd_data1,
           fwd_hit2, fwd_data2, count, empty, full
  );

  modport slave (
    input  in_valid, in_addr, in_data, drain_en, rd_addr1, rd_addr2,
    output in_ready, wr_en, wr_addr, wr_data, fwd_hit1, fwd_data1,
           fwd_hit2, fwd_data2, count, empty, full
  );
endinterface

// File: rtl/regfile_write_buffer_wb_forward_lookup.sv
// Forwarding lookup for one read port: newest queued entry wins, output stage is the fallback.
module wb_forward_lookup
  import regfile_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [$clog2(DEPTH):0]       cnt,
  input  logic                         out_vld,
  input  logic [ADDR_W-1:0]            out_addr,
  input  logic [DATA_W-1:0]            out_data,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  // Scan oldest to newest so a later (newer) match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    if (out_vld && out_addr == rd_addr) begin
      hit  = 1'b1;
      data = out_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < cnt && ent_addr[idx] == rd_addr) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
    if (rd_addr == ADDR_W'(ZERO_REG)) begin
      hit  = 1'b0;
      data = '0;
    end
  end
endmodule

// File: rtl/regfile_write_buffer.sv
// In-order write buffer in front of the register-file write port, with read forwarding.
module regfile_write_buffer
  import regfile_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input logic                  clk,
  input logic                  reset,
  regfile_write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [PTR_W-1:0]             wptr, rptr;
  logic [CNT_W-1:0]             cnt;
  logic                         vld_p1;
  logic [ADDR_W-1:0]            addr_p1;
  logic [DATA_W-1:0]            data_p1;
  logic                         full, empty, push, pop;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  // Register 0 writes are acknowledged but never stored.
  assign push  = bus.in_valid && !full && (bus.in_addr != ADDR_W'(ZERO_REG));
  assign pop   = bus.drain_en && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wptr] <= bus.in_addr;
      ent_data[wptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ---- output stage (p1): registered register-file write port ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= pop;
      if (pop) begin
        addr_p1 <= ent_addr[rptr];
        data_p1 <= ent_data[rptr];
      end
    end
  end

  assign bus.in_ready = !full;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = cnt;
  assign bus.wr_en    = vld_p1;
  assign bus.wr_addr  = addr_p1;
  assign bus.wr_data  = data_p1;

  wb_forward_lookup #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd1 (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .head     (rptr),
    .cnt      (cnt),
    .out_vld  (vld_p1),
    .out_addr (addr_p1),
    .out_data (data_p1),
    .rd_addr  (bus.rd_addr1),
    .hit      (bus.fwd_hit1),
    .data     (bus.fwd_data1)
  );

  wb_forward_lookup #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd2 (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .head     (rptr),
    .cnt      (cnt),
    .out_vld  (vld_p1),
    .out_addr (addr_p1),
    .out_data (data_p1),
    .rd_addr  (bus.rd_addr2),
    .hit      (bus.fwd_hit2),
    .data     (bus.fwd_data2)
  );
endmodule
